// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: issues a taken-branch redirect with zero latency, holds it until fetch accepts,
// then drops FETCH_LAT stale fetch responses; redirect_valid stays asserted while fetch_ready is low.
module branch_redirect_ctrl #(
  parameter int FETCH_LAT = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             jump_en,
  input  logic [31:0]      jump_target,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             misalign,
  output logic             flush_if,
  output logic             flush_id,
  output logic             drop_resp,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FETCH_LAT);

  state_t      state;
  logic [31:0] pend_pc;
  logic [3:0]  drain_cnt;
  logic        ex_fire;
  logic [31:0] tgt_aligned;

  // A stalled branch only fires on its first unstalled cycle.
  assign ex_fire     = ex_valid & ~ex_stall & jump_en;
  assign tgt_aligned = {jump_target[31:2], 2'b00};
  assign busy        = (state != IDLE);

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = pend_pc;
    misalign       = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    drop_resp      = 1'b0;
    case (state)
      IDLE: begin
        if (ex_fire) begin
          redirect_valid = 1'b1;
          redirect_pc    = tgt_aligned;
          misalign       = |jump_target[1:0];
          flush_if       = 1'b1;
          flush_id       = 1'b1;
        end
      end
      WAIT: begin
        redirect_valid = 1'b1;
        flush_if       = 1'b1;
        flush_id       = 1'b1;
      end
      DRAIN: begin
        drop_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pend_pc   <= '0;
      drain_cnt <= '0;
      taken_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_fire) begin
            pend_pc <= tgt_aligned;
            if (fetch_ready) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
              taken_cnt <= taken_cnt + CNT_W'(1);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Younger EX instructions are wrong-path here, so ex_fire is ignored.
          if (wait_cnt != {CNT_W{1'b1}}) wait_cnt <= wait_cnt + CNT_W'(1);
          if (fetch_ready) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
            taken_cnt <= taken_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
